// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: hunts SYNC_BYTE, parses LEN/payload/checksum and streams the verified payload.
// Optional inter-byte timeout is compiled in with `define UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ctrl_en,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_break,
    output logic       uart_rx_en,
    output logic       frm_valid,
    input  logic       frm_ready,
    output logic [7:0] frm_data,
    output logic       frm_last,
    output logic [7:0] frm_len,
    output logic       busy,
    output logic       err_csum,
    output logic       err_len,
    output logic       err_ovr,
    output logic       err_tmo
);

    localparam int         PW       = $clog2(MAX_LEN) + 1;
    localparam int         AW       = (PW > 1) ? PW - 1 : 1;
    localparam logic [7:0] LEN_MAX8 = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_rx_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [7:0]      r_sum;
    logic [7:0]      r_len;
    logic [7:0]      r_frm_data;
    logic            r_frm_valid;
    logic            r_frm_last;
    logic            r_busy;
    logic            r_err_csum;
    logic            r_err_len;
    logic            r_err_ovr;
    logic [7:0]      r_buf [0:MAX_LEN-1];

    logic            w_abort;
    logic [PW-1:0]   w_wptr_nxt;
    logic [PW-1:0]   w_rptr_nxt;
    logic            w_pay_done;
    logic            w_rd_last_nxt;
    logic [7:0]      w_sum_nxt;
    logic            w_len_ok;
    logic            w_hs;

    // Disable and BREAK both discard the frame silently and outrank any byte in the same cycle.
    assign w_abort       = !ctrl_en || rx_break;
    assign w_wptr_nxt    = r_wptr + PW'(1);
    assign w_rptr_nxt    = r_rptr + PW'(1);
    assign w_pay_done    = (8'(w_wptr_nxt) == r_len);
    assign w_rd_last_nxt = (8'(w_rptr_nxt) == r_len - 8'd1);
    assign w_sum_nxt     = r_sum + rx_data;
    assign w_len_ok      = (rx_data != 8'd0) && (rx_data <= LEN_MAX8);
    assign w_hs          = r_frm_valid && frm_ready;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err_tmo;
    logic          w_tmo_active;
    logic          w_tmo;

    assign w_tmo_active = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    assign w_tmo        = w_tmo_active && !rx_valid && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!resetn || w_abort || !w_tmo_active || rx_valid || w_tmo) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    assign err_tmo = r_err_tmo;
`else
    assign err_tmo = 1'b0;
`endif

    // Payload storage carries no reset; only bytes written this frame are ever read back.
    always_ff @(posedge clk) begin
        if (!w_abort && rx_valid && r_state == S_PAYLOAD) begin
            r_buf[r_wptr[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_HUNT;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_sum       <= 8'd0;
            r_len       <= 8'd0;
            r_frm_data  <= 8'd0;
            r_frm_valid <= 1'b0;
            r_frm_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_err_csum  <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_ovr   <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            r_err_tmo   <= 1'b0;
`endif
        end else begin
            r_err_csum <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_ovr  <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            r_err_tmo  <= 1'b0;
`endif
            if (w_abort) begin
                r_state     <= S_HUNT;
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_sum       <= 8'd0;
                r_frm_valid <= 1'b0;
                r_frm_last  <= 1'b0;
                r_busy      <= 1'b0;
            end
`ifdef UART_FRAME_TIMEOUT_EN
            else if (w_tmo) begin
                r_state   <= S_HUNT;
                r_busy    <= 1'b0;
                r_err_tmo <= 1'b1;
            end
`endif
            else begin
                case (r_state)
                    S_HUNT: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            r_state <= S_LEN;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (rx_valid) begin
                            if (w_len_ok) begin
                                r_len   <= rx_data;
                                r_sum   <= rx_data;
                                r_wptr  <= '0;
                                r_state <= S_PAYLOAD;
                            end else begin
                                r_err_len <= 1'b1;
                                r_state   <= S_HUNT;
                                r_busy    <= 1'b0;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_valid) begin
                            r_wptr <= w_wptr_nxt;
                            r_sum  <= w_sum_nxt;
                            if (w_pay_done) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (rx_valid) begin
                            if (w_sum_nxt == 8'd0) begin
                                r_state     <= S_DRAIN;
                                r_rptr      <= '0;
                                r_frm_valid <= 1'b1;
                                r_frm_data  <= r_buf[0];
                                r_frm_last  <= (r_len == 8'd1);
                            end else begin
                                r_err_csum <= 1'b1;
                                r_state    <= S_HUNT;
                                r_busy     <= 1'b0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (rx_valid) begin
                            r_err_ovr <= 1'b1;
                        end
                        // Next byte is preloaded on each handshake so a held-high ready drains without bubbles.
                        if (w_hs) begin
                            if (r_frm_last) begin
                                r_frm_valid <= 1'b0;
                                r_frm_last  <= 1'b0;
                                r_state     <= S_HUNT;
                                r_busy      <= 1'b0;
                            end else begin
                                r_rptr     <= w_rptr_nxt;
                                r_frm_data <= r_buf[w_rptr_nxt[AW-1:0]];
                                r_frm_last <= w_rd_last_nxt;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_HUNT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign uart_rx_en = ctrl_en;
    assign frm_valid  = r_frm_valid;
    assign frm_data   = r_frm_data;
    assign frm_last   = r_frm_last;
    assign frm_len    = r_len;
    assign busy       = r_busy;
    assign err_csum   = r_err_csum;
    assign err_len    = r_err_len;
    assign err_ovr    = r_err_ovr;

endmodule
